// File: rtl/pht_update_ctrl.sv
// PHT update controller: serves lookups on the array read port and drains queued
// resolved-branch updates as read-modify-write of saturating counters.
module pht_update_ctrl #(
  parameter int S_INDEX = 4,
  parameter int CTR_W   = 2,
  parameter int Q_DEPTH = 4
) (
  input  logic               clk0,
  input  logic               rst0_n,
  input  logic               pred_req,
  input  logic [S_INDEX-1:0] pred_idx,
  output logic               pred_valid,
  output logic [CTR_W-1:0]   pred_ctr,
  output logic               pred_taken,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [S_INDEX-1:0] upd_idx,
  input  logic               upd_taken,
  output logic               busy,
  output logic               arr_csb0,
  output logic               arr_web0,
  output logic [S_INDEX-1:0] arr_addr0,
  output logic [S_INDEX-1:0] arr_addr1,
  output logic [CTR_W-1:0]   arr_din0,
  input  logic [CTR_W-1:0]   arr_dout0
);

  localparam int PW = $clog2(Q_DEPTH);

  typedef struct packed {
    logic [S_INDEX-1:0] idx;
    logic               taken;
  } upd_t;

  typedef enum logic {IDLE, RD} state_t;

  state_t            state_q, state_d;
  upd_t              fifo_q [Q_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              pred_valid_q, pred_valid_d;
  logic              bypass_q, bypass_d;
  logic [CTR_W-1:0]  bypass_val_q, bypass_val_d;
  logic [CTR_W-1:0]  new_ctr;
  logic              full, empty, push, pop;
  upd_t              head;

  assign full  = (cnt_q == (PW+1)'(Q_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];
  assign push  = upd_valid && !full;
  assign pop   = (state_q == RD);

  // Saturating step of the head counter read back in RD.
  always_comb begin
    new_ctr = arr_dout0;
    if (head.taken) begin
      if (arr_dout0 != '1) new_ctr = arr_dout0 + CTR_W'(1);
    end else begin
      if (arr_dout0 != '0) new_ctr = arr_dout0 - CTR_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    pred_valid_d = pred_req;
    bypass_d     = 1'b0;
    bypass_val_d = bypass_val_q;
    case (state_q)
      IDLE: if (!empty && !pred_req) state_d = RD;
      RD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    // The array read launched now misses this cycle's write, so forward it.
    if (state_q == RD && pred_req && pred_idx == head.idx) begin
      bypass_d     = 1'b1;
      bypass_val_d = new_ctr;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pred_valid_q <= 1'b0;
      bypass_q     <= 1'b0;
      bypass_val_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      pred_valid_q <= pred_valid_d;
      bypass_q     <= bypass_d;
      bypass_val_q <= bypass_val_d;
    end
  end

  always_ff @(posedge clk0) begin
    if (push) fifo_q[wr_ptr_q] <= '{idx: upd_idx, taken: upd_taken};
  end

  assign upd_ready  = !full;
  assign busy       = !empty || (state_q != IDLE);
  assign pred_valid = pred_valid_q;
  assign pred_ctr   = bypass_q ? bypass_val_q : arr_dout0;
  assign pred_taken = pred_ctr[CTR_W-1];

  assign arr_csb0  = !rst0_n;
  assign arr_web0  = (state_q != RD);
  assign arr_addr0 = head.idx;
  assign arr_din0  = new_ctr;
  assign arr_addr1 = pred_req ? pred_idx : head.idx;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Bench for pht_update_ctrl: behavioural flop-array model, directed stimulus,
// lookup results checked by a scoreboard monitor.
module tb_pht_update_ctrl;
  logic       clk0 = 1'b0;
  logic       rst0_n;
  logic       pred_req, pred_valid, pred_taken;
  logic [3:0] pred_idx;
  logic [1:0] pred_ctr;
  logic       upd_valid, upd_ready, upd_taken, busy;
  logic [3:0] upd_idx;
  logic       arr_csb0, arr_web0;
  logic [3:0] arr_addr0, arr_addr1;
  logic [1:0] arr_din0, arr_dout0;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  always #5 clk0 = ~clk0;

  pht_update_ctrl #(.S_INDEX(4), .CTR_W(2), .Q_DEPTH(4)) dut (
    .clk0(clk0), .rst0_n(rst0_n),
    .pred_req(pred_req), .pred_idx(pred_idx), .pred_valid(pred_valid),
    .pred_ctr(pred_ctr), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .busy(busy),
    .arr_csb0(arr_csb0), .arr_web0(arr_web0), .arr_addr0(arr_addr0),
    .arr_addr1(arr_addr1), .arr_din0(arr_din0), .arr_dout0(arr_dout0)
  );

  // Array model: write lands one cycle after it is presented; read address is
  // registered and the data reflects writes landed by the previous edge.
  logic [1:0] mem [16];
  logic [3:0] raddr_q;
  logic       pw_v;
  logic [3:0] pw_a;
  logic [1:0] pw_d;
  logic       mem_clr;

  always @(posedge clk0) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 2'd0;
    end else if (pw_v) begin
      mem[pw_a] <= pw_d;
    end
    pw_v <= !arr_csb0 && !arr_web0;
    pw_a <= arr_addr0;
    pw_d <= arr_din0;
    if (!arr_csb0) raddr_q <= arr_addr1;
  end
  assign arr_dout0 = mem[raddr_q];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk0) begin
    if (rst0_n && pred_valid) begin
      if (exp_q.size() == 0) begin
        chk("pred_unexpected", 1, 0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        chk("pred_ctr", pred_ctr, e);
        chk("pred_taken", pred_taken, e[1]);
      end
    end
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) tick();
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_update(input logic [3:0] idx, input logic tk);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = tk;
    for (int k = 0; k < 100 && !upd_ready; k++) tick();
    chk("upd_accept_timeout", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] idx, input logic [1:0] e);
    pred_req = 1'b1; pred_idx = idx;
    exp_q.push_back(e);
    tick();
    pred_req = 1'b0;
  endtask

  initial begin
    int acc, web_lo, writes, last, gap_bad;
    logic got5, push5;
    rst0_n = 1'b0; pred_req = 1'b0; pred_idx = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; mem_clr = 1'b1;
    repeat (3) tick();
    mem_clr = 1'b0;
    // 1: reset state
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_upd_ready", upd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_web0", arr_web0, 1);
    chk("rst_csb0", arr_csb0, 1);
    rst0_n = 1'b1;
    #1;
    chk("run_csb0", arr_csb0, 0);
    tick();

    // 2: single increments
    do_update(4'd3, 1'b1); wait_idle(); lookup(4'd3, 2'd1);
    do_update(4'd3, 1'b1); wait_idle(); lookup(4'd3, 2'd2);

    // 3: saturation both ways
    for (int i = 0; i < 6; i++) do_update(4'd5, 1'b1);
    wait_idle(); lookup(4'd5, 2'd3);
    for (int i = 0; i < 4; i++) do_update(4'd5, 1'b0);
    wait_idle(); lookup(4'd5, 2'd0);
    do_update(4'd5, 1'b0);
    wait_idle(); lookup(4'd5, 2'd0);

    // 4: lookup collides with the write in RD
    chk("t4_pre_mem7", mem[7], 0);
    do_update(4'd7, 1'b1);
    tick();
    chk("t4_in_rd", arr_web0, 0);
    lookup(4'd7, 2'd1);
    wait_idle(); repeat (2) tick();
    chk("t4_mem7", mem[7], 1);
    lookup(4'd7, 2'd1);

    // 5: lookups starve the RMW; FIFO fills
    acc = 0; web_lo = 0;
    for (int i = 0; i < 12; i++) begin
      pred_req = 1'b1; pred_idx = 4'd0; exp_q.push_back(2'd0);
      if (i < 5) begin upd_valid = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1; end
      if (i == 4) chk("t5_ready_full", upd_ready, 0);
      if (upd_valid && upd_ready) acc++;
      if (!arr_web0) web_lo++;
      tick();
    end
    pred_req = 1'b0;
    chk("t5_accepted", acc, 4);
    chk("t5_no_writes", web_lo, 0);
    writes = 0; last = -1; gap_bad = 0; got5 = 1'b0;
    for (int k = 0; k < 40 && !(got5 && !busy); k++) begin
      if (!arr_web0) begin
        if (last >= 0 && k - last != 2) gap_bad++;
        last = k; writes++;
      end
      push5 = upd_valid && upd_ready;
      tick();
      if (push5) begin upd_valid = 1'b0; got5 = 1'b1; end
    end
    chk("t5_fifth_accepted", got5, 1);
    chk("t5_writes", writes, 5);
    chk("t5_write_gap", gap_bad, 0);
    repeat (2) tick();
    chk("t5_mem9", mem[9], 3);
    lookup(4'd9, 2'd3);

    // 6: async reset during RD abandons the update
    for (int j = 0; j < 3; j++) begin
      pred_req = 1'b1; pred_idx = 4'd0; exp_q.push_back(2'd0);
      upd_valid = 1'b1; upd_idx = 4'd11; upd_taken = 1'b1;
      chk("t6_ready", upd_ready, 1);
      tick();
    end
    pred_req = 1'b0; upd_valid = 1'b0;
    tick();
    chk("t6_in_rd", arr_web0, 0);
    #2 rst0_n = 1'b0;
    #1;
    chk("t6_rst_web0", arr_web0, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_csb0", arr_csb0, 1);
    repeat (2) tick();
    rst0_n = 1'b1;
    repeat (4) tick();
    chk("t6_busy_after", busy, 0);
    chk("t6_mem11", mem[11], 0);

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
